// File: rtl/mem_txn_scheduler.sv
// Transaction scheduler: arbitrates data/fetch ports onto memory_interface TX messages,
// bounds outstanding reads and routes in-order RX responses back to their requester.
module mem_txn_scheduler #(
  parameter int  IO_BITS         = 2,
  parameter int  TX_CMD_BITS     = 2,
  parameter int  PAYLOAD_CYCLES  = 8,
  parameter int  MAX_OUTSTANDING = 2,
  localparam int W               = IO_BITS * PAYLOAD_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d_valid,
  input  logic                   d_write,
  input  logic [W-1:0]           d_addr,
  input  logic [W-1:0]           d_wdata,
  output logic                   d_ready,
  input  logic                   f_valid,
  input  logic [W-1:0]           f_addr,
  output logic                   f_ready,
  output logic [W-1:0]           rdata,
  output logic                   d_rvalid,
  output logic                   f_rvalid,
  output logic                   rx_error,
  output logic                   tx_command_valid,
  output logic [TX_CMD_BITS-1:0] tx_command,
  input  logic                   tx_command_started,
  output logic [IO_BITS-1:0]     tx_data,
  input  logic                   tx_data_next,
  input  logic                   tx_done,
  input  logic                   rx_data_valid,
  input  logic                   rx_done,
  input  logic [IO_BITS-1:0]     rx_pins
);

  localparam logic [TX_CMD_BITS-1:0] CMD_READ  = TX_CMD_BITS'(0);
  localparam logic [TX_CMD_BITS-1:0] CMD_WADDR = TX_CMD_BITS'(1);
  localparam logic [TX_CMD_BITS-1:0] CMD_WDATA = TX_CMD_BITS'(2);
  localparam logic [2:0]             MAX_OUT_C  = 3'(MAX_OUTSTANDING);
  localparam logic [1:0]             LAST_PTR_C = 2'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_SEND = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic                   rr_fetch_last_q, rr_fetch_last_d;
  logic [TX_CMD_BITS-1:0] cmd_q, cmd_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [W-1:0]           tx_shift_q, tx_shift_d;
  logic [W-1:0]           wdata_q, wdata_d;
  logic                   req_id_q, req_id_d;
  logic                   req_write_q, req_write_d;
  logic [3:0]             id_fifo_q, id_fifo_d;
  logic [1:0]             wr_ptr_q, wr_ptr_d;
  logic [1:0]             rd_ptr_q, rd_ptr_d;
  logic [2:0]             outstanding_q, outstanding_d;
  logic [W-IO_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic [W-1:0]           rdata_q, rdata_d;
  logic                   d_rvalid_q, d_rvalid_d;
  logic                   f_rvalid_q, f_rvalid_d;
  logic                   rx_error_q, rx_error_d;

  logic         gnt_data, gnt_fetch, push, pop, read_ok, data_elig, fetch_elig;
  logic [W-1:0] rx_word;

  assign read_ok    = (outstanding_q < MAX_OUT_C);
  assign data_elig  = d_valid && (d_write || read_ok);
  assign fetch_elig = f_valid && read_ok;
  assign rx_word    = {rx_pins, rx_shift_q};

  // Next-state logic: arbitration, TX sequencing, ID FIFO and RX assembly.
  always_comb begin
    state_d         = state_q;
    rr_fetch_last_d = rr_fetch_last_q;
    cmd_d           = cmd_q;
    cmd_valid_d     = cmd_valid_q;
    wdata_d         = wdata_q;
    req_id_d        = req_id_q;
    req_write_d     = req_write_q;
    id_fifo_d       = id_fifo_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    outstanding_d   = outstanding_q;
    rx_shift_d      = rx_shift_q;
    rdata_d         = rdata_q;
    d_rvalid_d      = 1'b0;
    f_rvalid_d      = 1'b0;
    rx_error_d      = rx_error_q;
    gnt_data        = 1'b0;
    gnt_fetch       = 1'b0;

    if (tx_data_next && (state_q != ST_IDLE)) begin
      tx_shift_d = tx_shift_q >> IO_BITS;
    end else begin
      tx_shift_d = tx_shift_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (data_elig && (!fetch_elig || rr_fetch_last_q)) begin
          gnt_data = 1'b1;
        end else if (fetch_elig) begin
          gnt_fetch = 1'b1;
        end else begin
          gnt_data  = 1'b0;
          gnt_fetch = 1'b0;
        end
        if (gnt_data || gnt_fetch) begin
          state_d         = ST_ISSUE;
          cmd_valid_d     = 1'b1;
          rr_fetch_last_d = gnt_fetch;
          req_id_d        = gnt_fetch;
          req_write_d     = gnt_data && d_write;
          cmd_d           = (gnt_data && d_write) ? CMD_WADDR : CMD_READ;
          tx_shift_d      = gnt_data ? d_addr : f_addr;
          wdata_d         = d_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (tx_command_started) begin
          state_d     = ST_SEND;
          cmd_valid_d = 1'b0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_SEND: begin
        // The data half of a write follows its address half with no gap for arbitration.
        if (tx_done && (cmd_q == CMD_WADDR)) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_d       = CMD_WDATA;
          tx_shift_d  = wdata_q;
        end else if (tx_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase

    push = (state_q == ST_ISSUE) && tx_command_started && !req_write_q;
    pop  = rx_done && (outstanding_q != 3'd0);

    if (push) begin
      id_fifo_d[wr_ptr_q] = req_id_q;
      wr_ptr_d            = (wr_ptr_q == LAST_PTR_C) ? 2'd0 : wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rx_data_valid) begin
      rx_shift_d = rx_word[W-1:IO_BITS];
    end else begin
      rx_shift_d = rx_shift_q;
    end

    if (pop) begin
      rdata_d    = rx_word;
      d_rvalid_d = ~id_fifo_q[rd_ptr_q];
      f_rvalid_d = id_fifo_q[rd_ptr_q];
      rd_ptr_d   = (rd_ptr_q == LAST_PTR_C) ? 2'd0 : rd_ptr_q + 2'd1;
    end else if (rx_done) begin
      rx_error_d = 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      rr_fetch_last_q <= 1'b1;
      cmd_q           <= '0;
      cmd_valid_q     <= 1'b0;
      tx_shift_q      <= '0;
      wdata_q         <= '0;
      req_id_q        <= 1'b0;
      req_write_q     <= 1'b0;
      id_fifo_q       <= 4'd0;
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      outstanding_q   <= 3'd0;
      rx_shift_q      <= '0;
      rdata_q         <= '0;
      d_rvalid_q      <= 1'b0;
      f_rvalid_q      <= 1'b0;
      rx_error_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_fetch_last_q <= rr_fetch_last_d;
      cmd_q           <= cmd_d;
      cmd_valid_q     <= cmd_valid_d;
      tx_shift_q      <= tx_shift_d;
      wdata_q         <= wdata_d;
      req_id_q        <= req_id_d;
      req_write_q     <= req_write_d;
      id_fifo_q       <= id_fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      outstanding_q   <= outstanding_d;
      rx_shift_q      <= rx_shift_d;
      rdata_q         <= rdata_d;
      d_rvalid_q      <= d_rvalid_d;
      f_rvalid_q      <= f_rvalid_d;
      rx_error_q      <= rx_error_d;
    end
  end

  assign d_ready          = gnt_data && !reset;
  assign f_ready          = gnt_fetch && !reset;
  assign tx_command_valid = cmd_valid_q;
  assign tx_command       = cmd_q;
  assign tx_data          = tx_shift_q[IO_BITS-1:0];
  assign rdata            = rdata_q;
  assign d_rvalid         = d_rvalid_q;
  assign f_rvalid         = f_rvalid_q;
  assign rx_error         = rx_error_q;

endmodule

// File: tb/tb_mem_txn_scheduler.sv
// Bench for mem_txn_scheduler: plays memory_interface, scoreboards TX messages
// against requests and checks routing of RX responses.
module tb_mem_txn_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        d_valid = 1'b0, d_write = 1'b0, f_valid = 1'b0;
  logic [15:0] d_addr = 16'h0, d_wdata = 16'h0, f_addr = 16'h0;
  logic        d_ready, f_ready, d_rvalid, f_rvalid, rx_error;
  logic [15:0] rdata;
  logic        tx_command_valid;
  logic [1:0]  tx_command, tx_data;
  logic        tx_command_started = 1'b0, tx_data_next = 1'b0, tx_done = 1'b0;
  logic        rx_data_valid = 1'b0, rx_done = 1'b0;
  logic [1:0]  rx_pins = 2'b00;

  mem_txn_scheduler dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .rdata(rdata), .d_rvalid(d_rvalid), .f_rvalid(f_rvalid), .rx_error(rx_error),
    .tx_command_valid(tx_command_valid), .tx_command(tx_command),
    .tx_command_started(tx_command_started), .tx_data(tx_data),
    .tx_data_next(tx_data_next), .tx_done(tx_done),
    .rx_data_valid(rx_data_valid), .rx_done(rx_done), .rx_pins(rx_pins)
  );

  initial forever #5 clk = ~clk;

  int          n_pass = 0, n_checks = 0;
  int          pulse_cnt = 0, exp_pulses = 0, msgs_done = 0, rs_phase = 0, beat = 0;
  int          f_wd_target = 0;
  bit          f_check_en = 1'b0, last_was_wa = 1'b0;
  logic [17:0] exp_tx[$];
  int          grant_log[$];
  logic [15:0] acc;
  logic [1:0]  cur_cmd;
  logic [17:0] e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  // memory_interface stand-in: accepts a command, clocks out 8 beats, then tx_done
  initial forever begin
    @(negedge clk);
    tx_command_started = 1'b0; tx_data_next = 1'b0; tx_done = 1'b0;
    if (reset) begin
      rs_phase = 0; last_was_wa = 1'b0;
    end else begin
      case (rs_phase)
        0: begin
          if (last_was_wa) begin
            check("wd_valid_u1", 32'(tx_command_valid), 32'd1);
            last_was_wa = 1'b0;
          end
          if (tx_command_valid) begin
            cur_cmd = tx_command; tx_command_started = 1'b1;
            rs_phase = 1; beat = 0; acc = 16'h0;
          end
        end
        1: begin
          acc[beat*2 +: 2] = tx_data; tx_data_next = 1'b1; beat++;
          if (beat == 8) rs_phase = 2;
        end
        default: begin
          tx_done = 1'b1; rs_phase = 0;
          e = (exp_tx.size() != 0) ? exp_tx.pop_front() : 18'h3FFFF;
          check("tx_cmd", 32'(cur_cmd), 32'(e[17:16]));
          check("tx_payload", 32'(acc), 32'(e[15:0]));
          check("tx_cmd_held", 32'(tx_command), 32'(cur_cmd));
          msgs_done++;
          last_was_wa = (cur_cmd == 2'd1);
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (d_rvalid || f_rvalid) pulse_cnt++;
  end

  task automatic req(input bit port, input bit wr, input logic [15:0] addr, input logic [15:0] data);
    bit got = 1'b0;
    @(negedge clk);
    if (port) begin f_valid = 1'b1; f_addr = addr; end
    else begin d_valid = 1'b1; d_write = wr; d_addr = addr; d_wdata = data; end
    for (int c = 0; c < 400 && !got; c++) begin
      #1;
      got = port ? f_ready : d_ready;
      if (!got) @(negedge clk);
    end
    check(port ? "f_grant" : "d_grant", 32'(got), 32'd1);
    if (got) begin
      grant_log.push_back(int'(port));
      check("cmd_valid_idle", 32'(tx_command_valid), 32'd0);
      if (port && f_check_en) check("f_after_wd", 32'(msgs_done), 32'(f_wd_target));
      if (wr) begin exp_tx.push_back({2'd1, addr}); exp_tx.push_back({2'd2, data}); end
      else exp_tx.push_back({2'd0, addr});
    end
    @(negedge clk);
    if (port) f_valid = 1'b0; else d_valid = 1'b0;
    if (got) check("cmd_valid_t1", 32'(tx_command_valid), 32'd1);
  endtask

  task automatic wait_msgs(input int target);
    int c = 0;
    while (msgs_done < target && c < 2000) begin @(negedge clk); c++; end
    check("tx_msgs_reached", 32'(msgs_done >= target), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // port: 0 = data, 1 = fetch, 2 = no read outstanding
  task automatic send_rx(input logic [15:0] word, input int port, output bit snap);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_data_valid = 1'b1; rx_pins = word[2*i +: 2]; rx_done = (i == 7);
    end
    @(negedge clk);
    rx_data_valid = 1'b0; rx_done = 1'b0; rx_pins = 2'b00;
    check("rsp_d_rvalid", 32'(d_rvalid), 32'(port == 0));
    check("rsp_f_rvalid", 32'(f_rvalid), 32'(port == 1));
    if (port != 2) begin
      check("rsp_rdata", 32'(rdata), 32'(word)); exp_pulses++;
    end else begin
      check("rx_error_set", 32'(rx_error), 32'd1);
    end
    #1 snap = d_ready || f_ready;
    @(negedge clk);
    check("rsp_pulse_width", 32'(d_rvalid || f_rvalid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_ready"}, 32'(d_ready), 32'd0);
    check({tag, "_rvalid"}, 32'({d_rvalid, f_rvalid}), 32'd0);
    check({tag, "_rx_error"}, 32'(rx_error), 32'd0);
    check({tag, "_cmd_valid"}, 32'(tx_command_valid), 32'd0);
    check({tag, "_cmd_data"}, 32'({tx_command, tx_data}), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_outstanding"}, 32'(dut.outstanding_q), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit snap;
    int base;
    int exp_ord[4] = '{0, 1, 0, 1};
    int c;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // single data read
    req(1'b0, 1'b0, 16'h1234, 16'h0);
    wait_msgs(1);
    send_rx(16'hBEEF, 0, snap);

    // write with a fetch arriving mid-write
    base = msgs_done; f_wd_target = base + 2; f_check_en = 1'b1;
    fork
      req(1'b0, 1'b1, 16'h0010, 16'hA5A5);
      begin repeat (3) @(negedge clk); req(1'b1, 1'b0, 16'h0040, 16'h0); end
    join
    f_check_en = 1'b0;
    wait_msgs(base + 3);
    send_rx(16'hC0DE, 1, snap);

    // both ports busy; third read blocked by the outstanding limit
    grant_log.delete();
    base = msgs_done;
    fork
      begin req(1'b0, 1'b0, 16'h0100, 16'h0); req(1'b0, 1'b0, 16'h0300, 16'h0); end
      begin req(1'b1, 1'b0, 16'h0200, 16'h0); req(1'b1, 1'b0, 16'h0400, 16'h0); end
    join_none
    wait_msgs(base + 2);
    check("outstanding_peak", 32'(dut.outstanding_q), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("third_blocked", 32'(d_ready || f_ready), 32'd0);
    end
    send_rx(16'h1111, 0, snap);
    check("unblock_d_next_cycle", 32'(snap), 32'd1);
    wait_msgs(base + 3);
    send_rx(16'h2222, 1, snap);
    check("unblock_f_next_cycle", 32'(snap), 32'd1);
    wait_msgs(base + 4);
    send_rx(16'h3333, 0, snap);
    send_rx(16'h4444, 1, snap);
    check("grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("grant_order", 32'(grant_log[i]), 32'(exp_ord[i]));

    // response with nothing outstanding
    send_rx(16'h5555, 2, snap);
    repeat (3) @(negedge clk);
    check("rx_error_sticky", 32'(rx_error), 32'd1);

    // reset in the middle of a READ
    req(1'b0, 1'b0, 16'h0ABC, 16'h0);
    c = 0;
    while (rs_phase != 1 && c < 50) begin @(negedge clk); c++; end
    check("send_reached", 32'(rs_phase == 1), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    exp_tx.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    base = msgs_done;
    req(1'b0, 1'b0, 16'h0321, 16'h0);
    wait_msgs(base + 1);
    send_rx(16'h7777, 0, snap);

    repeat (3) @(negedge clk);
    check("rvalid_pulses", 32'(pulse_cnt), 32'(exp_pulses));
    check("tx_leftover", 32'(exp_tx.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_txn_scheduler.md
# mem_txn_scheduler

Transaction scheduler in front of `memory_interface`. Arbitrates between a data port (read/write) and an instruction-fetch port (read-only), serializes each request into one or two TX messages, and limits outstanding reads. In-order RX responses are routed back to the port that issued the matching read. Sits between the CPU core and `memory_interface`; drives that block's TX command/data inputs and taps its RX status outputs.

## Interface
- `IO_BITS`, 2, pins per direction; must equal the `memory_interface` value
- `TX_CMD_BITS`, 2, command width; must equal the `memory_interface` value
- `PAYLOAD_CYCLES`, 8, payload cycles per message; word width `W = IO_BITS*PAYLOAD_CYCLES` (16 by default)
- `MAX_OUTSTANDING`, 2, maximum reads issued but not yet answered (1..4)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; shared with `memory_interface`
- `d_valid`  in  1  data-port request pending
- `d_write`  in  1  1 = write, 0 = read
- `d_addr`  in  W  data-port address
- `d_wdata`  in  W  write data
- `d_ready`  out  1  one-cycle pulse; request accepted and captured this cycle
- `f_valid`  in  1  fetch-port read request pending
- `f_addr`  in  W  fetch address
- `f_ready`  out  1  one-cycle pulse; fetch accepted
- `rdata`  out  W  read response word
- `d_rvalid`  out  1  `rdata` belongs to the data port (one-cycle pulse)
- `f_rvalid`  out  1  `rdata` belongs to the fetch port (one-cycle pulse)
- `rx_error`  out  1  sticky; RX message arrived with no read outstanding
- `tx_command_valid`  out  1  to `memory_interface`
- `tx_command`  out  TX_CMD_BITS  to `memory_interface`
- `tx_command_started`  in  1  from `memory_interface`
- `tx_data`  out  IO_BITS  to `memory_interface`
- `tx_data_next`  in  1  from `memory_interface`
- `tx_done`  in  1  from `memory_interface`
- `rx_data_valid`  in  1  from `memory_interface`
- `rx_done`  in  1  from `memory_interface`
- `rx_pins`  in  IO_BITS  raw RX pins, shared with `memory_interface`

## Operation
- Commands: `0` = READ (payload = address), `1` = WRITE_ADDR (payload = address), `2` = WRITE_DATA (payload = data). `3` is never issued.
- FSM states:
  - IDLE: picks a request.
  - ISSUE: holds `tx_command_valid=1` until `tx_command_started`.
  - SEND: waits for `tx_done`.
- IDLE eligibility:
  - A read is eligible only if `outstanding < MAX_OUTSTANDING`.
  - Writes are always eligible.
- Arbitration:
  - Round-robin. When both ports are eligible, the port not granted last wins. After reset, the data port wins first.
  - A sole eligible port always wins.
- Grant: pulse `d_ready`/`f_ready`. Capture command, address, data, requester ID and the write flag. Load the payload shift register with the address. Go to ISSUE.
- The `tx_command` register is held stable from ISSUE through the end of SEND.
- Payload serialization:
  - `tx_data` = shift register bits [IO_BITS-1:0]; LSB first.
  - Shift right by IO_BITS on each cycle with `tx_data_next=1`.
- SEND on `tx_done`:
  - READ or WRITE_DATA: go to IDLE.
  - WRITE_ADDR: load `d_wdata`, already captured at grant, into the shift register; set the command to WRITE_DATA; go to ISSUE. The two halves of a write are never interleaved with other messages.
- Read tracking:
  - On `tx_command_started` with command READ, push the requester ID into an ID FIFO of depth MAX_OUTSTANDING and increment `outstanding`.
- RX assembly:
  - Shift `rx_pins` into an RX register on every `rx_data_valid` cycle, LSB first.
  - On the `rx_done` cycle, the full word (including the current pins) is registered into `rdata`.
  - The cycle after `rx_done`, pulse `d_rvalid` or `f_rvalid` according to the FIFO head; pop the FIFO and decrement `outstanding`.
- Counter update when a push and a pop fall in the same cycle: `outstanding` is unchanged and the FIFO stays consistent.
- RX completing with the FIFO empty: set `rx_error` (sticky until reset), drop the word, no rvalid pulse, counters unchanged.

## Timing
- Reset values:
  - State IDLE, FIFO empty, `outstanding=0`, round-robin favours the data port.
  - Outputs `d_ready`, `f_ready`, `d_rvalid`, `f_rvalid`, `rx_error`, `tx_command_valid` = 0; `tx_command`, `tx_data`, `rdata` = 0.
- Reset mid-message: return to IDLE at the next edge. In-flight TX and RX state is discarded and no rvalid pulse is produced.
- Grant in cycle t gives `tx_command_valid=1` in cycle t+1. `tx_command_valid` is never asserted while in IDLE or SEND.
- After `tx_done` in cycle u:
  - the next grant is possible in u+1;
  - the WRITE_DATA `tx_command_valid` is asserted in u+1.
- The response pulse is exactly 1 cycle after `rx_done`, with `rdata` valid in the same cycle.
- A request held with valid=1 while ineligible or losing arbitration is never dropped.

## Test plan
- Single data read at addr 0x1234: READ issued. `tx_data` sequence (LSB first) 0,1,3,0,2,0,1,0. RX word 0xBEEF gives `d_rvalid=1`, `rdata=0xBEEF`, one cycle after `rx_done`.
- Data write addr 0x0010, data 0xA5A5: WRITE_ADDR then WRITE_DATA back-to-back. A concurrently pending `f_valid` is granted only after the WRITE_DATA `tx_done`.
- Both ports valid continuously: grants alternate d, f, d, f. Responses 0x1111 and 0x2222 route to `d_rvalid` then `f_rvalid`.
- MAX_OUTSTANDING=2, three reads with no RX: the third stays ungranted. The first response unblocks it the following cycle; `outstanding` peaks at 2.
- RX message with no outstanding read: `rx_error=1` and stays high; no rvalid pulse.
- Reset asserted during SEND of a READ: all outputs return to reset values next cycle; a following read completes normally.
